// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel readout block.
//   PIX_W_DEFAULT : default pixel code / conversion counter width
//   pix_idx_t     : pixel index {row, col}
//   ROW_*, COL_*  : row and column encodings
//   bin2gray / gray2bin : code conversions on a 32-bit container; callers
//                         zero-extend narrower codes and truncate the result.
package pixel_pkg;

    localparam int unsigned PIX_W_DEFAULT = 8;

    typedef logic [1:0] pix_idx_t;  // {row, col}

    localparam logic ROW_0 = 1'b0;
    localparam logic ROW_1 = 1'b1;
    localparam logic COL_0 = 1'b0;
    localparam logic COL_1 = 1'b1;

    localparam pix_idx_t LAST_PIX = 2'd3;

    typedef logic [31:0] code_t;

    function automatic code_t bin2gray(input code_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero upper bits leave the lower bits of the prefix-XOR unaffected.
    function automatic code_t gray2bin(input code_t gray);
        code_t bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Row-entry FIFO for the pixel readout.
//   clk, reset     : clock, synchronous active-low reset (pointers only)
//   push/push_data : write an entry; caller only pushes when accepted, which
//                    may be while full provided pop is asserted the same cycle
//   pop/pop_data   : head entry (combinational) and release of it
//   full, empty    : status, distinguished by an extra pointer bit
module pixel_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // When full with a coincident pop, the written slot is the head being
    // released this cycle, so the overwrite is safe.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pixel_readout.sv
// Column-parallel pixel readout: ramp counter for the pixel latches, row
// capture on read strobe falling edges, row FIFO and a 2-pixel serializer.
//   clk, reset        : clock, synchronous active-low reset
//   convert           : conversion phase strobe; drives the ramp counter
//   read1, read2      : row-0 / row-1 read strobes (read1 wins when both high)
//   pix_data          : selected row codes, col 0 in the low half
//   adc_code          : registered ramp code to the pixel latches
//   out_valid/ready   : pixel stream handshake
//   out_data, out_pix : pixel value (binary) and index {row, col}
//   overflow          : sticky, set when a row capture is dropped
//   frame_done        : pulse on transfer of pixel index 3
// Build option: define PIXEL_READOUT_GRAY_EN for a Gray-coded ramp; captured
// codes are then converted back to binary on the way out.
module pixel_readout import pixel_pkg::*; #(
    parameter int unsigned PIX_W      = PIX_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               convert,
    input  logic               read1,
    input  logic               read2,
    input  logic [2*PIX_W-1:0] pix_data,
    output logic [PIX_W-1:0]   adc_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_data,
    output logic [1:0]         out_pix,
    output logic               overflow,
    output logic               frame_done
);

    localparam int unsigned ENTRY_W = 1 + 2 * PIX_W;

    // Ramp counter
    logic             convert_q;
    logic [PIX_W-1:0] count_q;
    logic [PIX_W-1:0] adc_enc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            convert_q <= 1'b0;
            count_q   <= '0;
            adc_code  <= '0;
        end else begin
            convert_q <= convert;
            if (convert && !convert_q) begin
                count_q <= '0;
            end else if (convert && (count_q != '1)) begin
                count_q <= count_q + PIX_W'(1);
            end
            adc_code <= adc_enc;
        end
    end

    // Row capture
    logic               rd1_q;
    logic               rd2_q;
    logic [2*PIX_W-1:0] row_data_q;
    logic               rd2_eff;
    logic               fall1;
    logic               fall2;
    logic               push_req;
    logic               push_row;

    assign rd2_eff  = read2 & ~read1;
    assign fall1    = rd1_q & ~read1;
    assign fall2    = rd2_q & ~rd2_eff;
    // fall1 and fall2 are exclusive: rd2_q implies read1 was low last cycle.
    assign push_req = fall1 | fall2;
    assign push_row = fall1 ? ROW_0 : ROW_1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd1_q      <= 1'b0;
            rd2_q      <= 1'b0;
            row_data_q <= '0;
        end else begin
            rd1_q <= read1;
            rd2_q <= rd2_eff;
            if (read1 || rd2_eff) row_data_q <= pix_data;
        end
    end

    // Buffering and serialization
    logic               col_q;
    logic               overflow_q;
    logic               transfer;
    logic               pop;
    logic               push_ok;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [PIX_W-1:0]   head_code;
    logic [PIX_W-1:0]   head_bin;
    pix_idx_t           head_idx;

    assign transfer = out_valid && out_ready;
    assign pop      = transfer && (col_q == COL_1);
    assign push_ok  = !fifo_full || pop;
    assign push     = push_req && push_ok;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_row, row_data_q}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q      <= COL_0;
            overflow_q <= 1'b0;
        end else begin
            if (transfer) col_q <= ~col_q;
            if (push_req && !push_ok) overflow_q <= 1'b1;
        end
    end

    assign head_code = col_q ? head[2*PIX_W-1:PIX_W] : head[PIX_W-1:0];
    assign head_idx  = {head[ENTRY_W-1], col_q};

`ifdef PIXEL_READOUT_GRAY_EN
    assign adc_enc  = PIX_W'(bin2gray(code_t'(count_q)));
    assign head_bin = PIX_W'(gray2bin(code_t'(head_code)));
`else
    assign adc_enc  = count_q;
    assign head_bin = head_code;
`endif

    // Outputs are forced to zero while nothing is buffered so reset state is clean.
    assign out_valid  = !fifo_empty;
    assign out_data   = out_valid ? head_bin : '0;
    assign out_pix    = out_valid ? head_idx : 2'd0;
    assign overflow   = overflow_q;
    assign frame_done = transfer && (out_pix == LAST_PIX);

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 SHALL have parameter PIX_W, default 8, width of one pixel code and of the conversion counter.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of row entries buffered (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port convert  input  1  conversion phase strobe from the pixel state sequencer.
REQ-006 SHALL have port read1  input  1  row-0 read phase strobe.
REQ-007 SHALL have port read2  input  1  row-1 read phase strobe.
REQ-008 SHALL have port pix_data  input  2*PIX_W  selected row's codes; [PIX_W-1:0]=col 0, upper half=col 1.
REQ-009 SHALL have port adc_code  output  PIX_W  ramp code broadcast to the pixel latches.
REQ-010 SHALL have port out_valid  output  1  output pixel available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid&&out_ready.
REQ-012 SHALL have port out_data  output  PIX_W  pixel value, binary.
REQ-013 SHALL have port out_pix  output  2  pixel index {row,col}.
REQ-014 SHALL have port overflow  output  1  sticky: a row capture was dropped.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse on transfer of pixel index 3.

Function
REQ-016 SHALL register convert; the cycle convert goes 0->1, counter loads 0; each subsequent cycle with convert=1 it increments by 1, saturating at 2^PIX_W-1.
REQ-017 SHALL hold the counter while convert=0; a new 0->1 edge restarts from 0 even when saturated.
REQ-018 SHALL drive adc_code from a register (encoding per REQ-030/031), one cycle after counter update.
REQ-019 SHALL sample pix_data into a row register every cycle the active read strobe is 1.
REQ-020 SHALL detect a read strobe 1->0 edge and, in that cycle, push {row, sampled pix_data} into the FIFO; row=0 for read1, 1 for read2.
REQ-021 SHALL treat read1 and read2 both high as read1 only (read2 ignored that cycle).
REQ-022 SHALL accept a push when FIFO not full, or when full and the head entry's second pixel transfers in the same cycle; otherwise drop the entry and set overflow to 1.
REQ-023 SHALL serialize head entry as col 0 then col 1; pop entry after col 1 transfers.
REQ-024 SHALL assert out_valid the cycle after a push into an empty FIFO (latency 1).
REQ-025 SHALL hold out_data and out_pix stable while out_valid=1 and out_ready=0.
REQ-026 SHALL allow one transfer per cycle, back-to-back with out_ready held high.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-028 SHALL, when reset=0 at a rising clk edge, clear: counter, adc_code=0, out_valid=0, out_data=0, out_pix=0, overflow=0, frame_done=0, FIFO empty, serializer at col 0, edge registers=0.
REQ-029 SHALL discard any in-flight row or partially serialized entry on reset mid-operation; no strobe edge is detected in the first cycle after reset release.

Configuration
REQ-030 SHALL, with PIXEL_READOUT_GRAY_EN defined, drive adc_code Gray-coded (bin^(bin>>1)) and convert each captured code Gray->binary before out_data.
REQ-031 SHALL, without PIXEL_READOUT_GRAY_EN, drive adc_code binary and pass captured codes unchanged.

Structure
REQ-032 SHALL take PIX_W default, pixel index type, row/col encodings, and bin2gray/gray2bin functions from shared package pixel_pkg.
REQ-033 SHALL implement buffering in sub-module pixel_fifo (width 1+2*PIX_W, depth FIFO_DEPTH, push/pop/full/empty).

Verification
REQ-034 SHALL test convert high 10 cycles -> adc_code binary 0..9 (GRAY_EN: 0,1,3,2,6,7,5,4,12,13); convert high 300 cycles -> holds 255.
REQ-035 SHALL test read1 with pix_data=0x5A3C, read2 with 0x7F01, out_ready=1 -> out_data 0x3C,0x5A,0x01,0x7F, out_pix 0,1,2,3, frame_done on 4th.
REQ-036 SHALL test out_ready=0 for 5 rows (FIFO_DEPTH=4) -> 4 entries held, overflow=1; release -> 8 pixels in order, overflow stays 1.
REQ-037 SHALL test full FIFO with pop of col 1 coincident with read falling edge -> entry accepted, overflow=0.
REQ-038 SHALL test reset=0 mid-serialization (after col 0) -> out_valid=0 next cycle, FIFO empty, all outputs 0.
REQ-039 SHALL test read1 and read2 high together then low -> single row-0 entry only.
